// File: rtl/gray_count_sched_pkg.sv
// Shared types and helpers for the Gray-code counter scheduler.
// Holds the command opcode encoding, the scheduler state encoding and a
// binary-to-Gray conversion used by the counter datapath.
package gray_count_sched_pkg;

  typedef enum logic [1:0] {
    OP_RUN_N = 2'b00,
    OP_FREE  = 2'b01,
    OP_STOP  = 2'b10,
    OP_LOAD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_STEP = 2'b01,
    ST_FREE = 2'b10
  } state_e;

  // Widest counter the Gray helper supports; callers resize to their width.
  localparam int MAX_W = 32;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_count_core.sv
// Counter datapath: owns the binary register and presents it Gray-coded.
// Load takes priority over an advance. When GRAY_COUNT_SCHED_DIR_EN is
// defined a dec input counts down, with wrap on the 0 -> all-ones step.
module gray_count_core
  import gray_count_sched_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
`ifdef GRAY_COUNT_SCHED_DIR_EN
  input  logic             dec,
`endif
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] bin_nxt;
  logic             wrap_nxt;

  // Pick the next binary value and flag the roll-over step.
  always_comb begin
    bin_nxt  = bin;
    wrap_nxt = 1'b0;
    if (load) begin
      bin_nxt = load_val;
    end else if (inc) begin
      bin_nxt  = bin + 1'b1;
      wrap_nxt = &bin;
    end
`ifdef GRAY_COUNT_SCHED_DIR_EN
    else if (dec) begin
      bin_nxt  = bin - 1'b1;
      wrap_nxt = ~|bin;
    end
`endif
  end

  // Binary register with its Gray image registered on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin   <= '0;
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      bin   <= bin_nxt;
      count <= WIDTH'(bin2gray(MAX_W'(bin_nxt)));
      wrap  <= wrap_nxt;
    end
  end

endmodule

// File: rtl/gray_count_sched.sv
// Command-driven scheduler for the Gray-code counter.
// Accepts RUN_N / FREE / STOP / LOAD over valid/ready, paces advances with
// a prescaler and reports busy, done and wrap. Optional macro
// GRAY_COUNT_SCHED_DIR_EN adds a cmd_dir input (1 = count down).
module gray_count_sched
  import gray_count_sched_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [WIDTH-1:0]      cmd_arg,
`ifdef GRAY_COUNT_SCHED_DIR_EN
  input  logic                  cmd_dir,
`endif
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  done,
  output logic                  wrap
);

  state_e                state;
  state_e                state_nxt;
  op_e                   op;
  logic [PRESCALE_W-1:0] p_q;
  logic [PRESCALE_W-1:0] p_nxt;
  logic [PRESCALE_W-1:0] presc_cnt;
  logic [PRESCALE_W-1:0] presc_nxt;
  logic [WIDTH-1:0]      steps_left;
  logic [WIDTH-1:0]      steps_nxt;
  logic                  done_q;
  logic                  done_nxt;
  logic                  accept;
  logic                  tick;
  logic                  advance;
  logic                  load_en;
  logic                  core_inc;
`ifdef GRAY_COUNT_SCHED_DIR_EN
  logic                  dir_q;
  logic                  dir_nxt;
  logic                  core_dec;
`endif

  assign op        = op_e'(cmd_op);
  assign busy      = (state != ST_IDLE);
  assign cmd_ready = (state == ST_IDLE) || (op == OP_STOP);
  assign accept    = cmd_valid && cmd_ready;
  assign tick      = busy && (presc_cnt == p_q);
  assign done      = done_q;

  // Next-state, prescaler and step bookkeeping; STOP beats a coincident tick.
  always_comb begin
    state_nxt = state;
    p_nxt     = p_q;
    presc_nxt = presc_cnt;
    steps_nxt = steps_left;
    done_nxt  = 1'b0;
    advance   = 1'b0;
    load_en   = 1'b0;
`ifdef GRAY_COUNT_SCHED_DIR_EN
    dir_nxt   = dir_q;
`endif
    case (state)
      ST_IDLE: begin
        presc_nxt = '0;
        if (accept) begin
          case (op)
            OP_RUN_N: begin
              if (cmd_arg == '0) begin
                done_nxt = 1'b1;
              end else begin
                state_nxt = ST_STEP;
                steps_nxt = cmd_arg;
                p_nxt     = prescale;
`ifdef GRAY_COUNT_SCHED_DIR_EN
                dir_nxt   = cmd_dir;
`endif
              end
            end
            OP_FREE: begin
              state_nxt = ST_FREE;
              p_nxt     = prescale;
`ifdef GRAY_COUNT_SCHED_DIR_EN
              dir_nxt   = cmd_dir;
`endif
            end
            OP_LOAD: load_en = 1'b1;
            default: ;
          endcase
        end
      end
      ST_STEP, ST_FREE: begin
        presc_nxt = tick ? '0 : presc_cnt + 1'b1;
        if (accept && (op == OP_STOP)) begin
          state_nxt = ST_IDLE;
        end else if (tick) begin
          advance = 1'b1;
          if (state == ST_STEP) begin
            if (steps_left == WIDTH'(1)) begin
              state_nxt = ST_IDLE;
              done_nxt  = 1'b1;
            end else begin
              steps_nxt = steps_left - 1'b1;
            end
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Scheduler registers; reset overrides any command on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      p_q        <= '0;
      presc_cnt  <= '0;
      steps_left <= '0;
      done_q     <= 1'b0;
`ifdef GRAY_COUNT_SCHED_DIR_EN
      dir_q      <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      p_q        <= p_nxt;
      presc_cnt  <= presc_nxt;
      steps_left <= steps_nxt;
      done_q     <= done_nxt;
`ifdef GRAY_COUNT_SCHED_DIR_EN
      dir_q      <= dir_nxt;
`endif
    end
  end

`ifdef GRAY_COUNT_SCHED_DIR_EN
  assign core_inc = advance && !dir_q;
  assign core_dec = advance && dir_q;
`else
  assign core_inc = advance;
`endif

  gray_count_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .inc      (core_inc),
`ifdef GRAY_COUNT_SCHED_DIR_EN
    .dec      (core_dec),
`endif
    .load     (load_en),
    .load_val (cmd_arg),
    .count    (count),
    .wrap     (wrap)
  );

endmodule

// File: tb/tb_gray_count_sched.sv
// Self-checking bench for gray_count_sched: directed scenarios with literal
// expectations, then randomized commands checked every cycle against a
// cycle-scheduled behavioural model.
module tb_gray_count_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_arg = 8'd0;
  logic [7:0] prescale = 8'd0;
  logic       cmd_ready;
  logic [7:0] count;
  logic       busy;
  logic       done;
  logic       wrap;
`ifdef GRAY_COUNT_SCHED_DIR_EN
  logic       cmd_dir = 1'b0;
`endif

  gray_count_sched #(
    .WIDTH(8),
    .PRESCALE_W(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
`ifdef GRAY_COUNT_SCHED_DIR_EN
    .cmd_dir   (cmd_dir),
`endif
    .prescale  (prescale),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Model: mode 0 idle, 1 counted run, 2 free run; advances at absolute edges.
  int     m_mode = 0;
  int     m_bin = 0;
  int     m_left = 0;
  int     m_p = 0;
  bit     m_done = 1'b0;
  bit     m_wrap = 1'b0;
  longint m_next = 0;
  longint cyc = 0;

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit v, input int op, input int arg, input int presc);
    cmd_valid = v;
    cmd_op    = 2'(op);
    cmd_arg   = 8'(arg);
    prescale  = 8'(presc);
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  // Reference model updated on each rising edge from the inputs seen there.
  always @(posedge clk) begin : ref_model
    bit acc;
    acc = cmd_valid && (m_mode == 0 || cmd_op == 2'd2);
    m_done = 1'b0;
    m_wrap = 1'b0;
    if (reset) begin
      m_mode = 0;
      m_bin  = 0;
    end else if (m_mode != 0 && acc) begin
      m_mode = 0;
    end else if (m_mode != 0 && cyc == m_next) begin
      m_wrap = (m_bin == 255);
      m_bin  = (m_bin + 1) % 256;
      m_next = m_next + m_p + 1;
      if (m_mode == 1) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_mode = 0;
          m_done = 1'b1;
        end
      end
    end else if (m_mode == 0 && acc) begin
      case (cmd_op)
        2'd0: begin
          if (cmd_arg == 8'd0) m_done = 1'b1;
          else begin
            m_mode = 1;
            m_left = int'(cmd_arg);
            m_p    = int'(prescale);
            m_next = cyc + m_p + 1;
          end
        end
        2'd1: begin
          m_mode = 2;
          m_p    = int'(prescale);
          m_next = cyc + m_p + 1;
        end
        2'd3: m_bin = int'(cmd_arg);
        default: ;
      endcase
    end
    cyc++;
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("model_count", int'(count), gray(m_bin));
      checkOutput("model_busy", int'(busy), int'(m_mode != 0));
      checkOutput("model_done", int'(done), int'(m_done));
      checkOutput("model_wrap", int'(wrap), int'(m_wrap));
      checkOutput("model_ready", int'(cmd_ready), int'(m_mode == 0 || cmd_op == 2'd2));
    end
  end

  initial begin
    int exp5 [5] = '{1, 3, 2, 6, 7};

    // Reset held three cycles, then released.
    reset = 1'b1;
    repeat (3) tick_clk();
    reset = 1'b0;
    check_en = 1'b1;
    tick_clk();
    checkOutput("rst_count", int'(count), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_wrap", int'(wrap), 0);
    checkOutput("rst_ready", int'(cmd_ready), 1);

    // RUN_N 5 with no prescale.
    applyStimulus(1, 0, 5, 0);
    tick_clk();
    applyStimulus(0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      tick_clk();
      checkOutput("run5_count", int'(count), exp5[k]);
      checkOutput("run5_done", int'(done), int'(k == 4));
      checkOutput("run5_busy", int'(busy), int'(k != 4));
    end
    tick_clk();
    checkOutput("run5_done_pulse", int'(done), 0);

    // RUN_N 2 with prescale 2 from zero; a second RUN_N stalls meanwhile.
    applyStimulus(1, 3, 0, 0);
    tick_clk();
    applyStimulus(1, 0, 2, 2);
    tick_clk();
    applyStimulus(1, 0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      checkOutput("stall_ready", int'(cmd_ready), 0);
      tick_clk();
      checkOutput("presc2_count", int'(count), (k < 3) ? 0 : ((k < 6) ? 1 : 3));
    end
    checkOutput("presc2_done", int'(done), 1);
    checkOutput("presc2_busy", int'(busy), 0);
    applyStimulus(0, 0, 0, 0);
    tick_clk();

    // LOAD all-ones then a single step wraps to zero.
    applyStimulus(1, 3, 8'hFF, 0);
    tick_clk();
    applyStimulus(0, 0, 0, 0);
    checkOutput("load_count", int'(count), 8'h80);
    checkOutput("load_wrap", int'(wrap), 0);
    checkOutput("load_done", int'(done), 0);
    applyStimulus(1, 0, 1, 0);
    tick_clk();
    applyStimulus(0, 0, 0, 0);
    tick_clk();
    checkOutput("wrap_count", int'(count), 0);
    checkOutput("wrap_wrap", int'(wrap), 1);
    checkOutput("wrap_done", int'(done), 1);
    tick_clk();
    checkOutput("wrap_pulse", int'(wrap), 0);

    // FREE from zero, STOP after four advances.
    applyStimulus(1, 1, 0, 0);
    tick_clk();
    applyStimulus(0, 0, 0, 0);
    repeat (4) tick_clk();
    checkOutput("free_count", int'(count), 8'h06);
    applyStimulus(1, 2, 0, 0);
    tick_clk();
    applyStimulus(0, 0, 0, 0);
    checkOutput("stop_count", int'(count), 8'h06);
    checkOutput("stop_busy", int'(busy), 0);
    checkOutput("stop_done", int'(done), 0);

    // STOP on the final RUN_N tick: binary 4 -> 5, last step suppressed.
    applyStimulus(1, 0, 2, 1);
    tick_clk();
    applyStimulus(0, 0, 0, 0);
    tick_clk();
    tick_clk();
    checkOutput("fin_mid_count", int'(count), 8'h07);
    tick_clk();
    applyStimulus(1, 2, 0, 0);
    tick_clk();
    applyStimulus(0, 0, 0, 0);
    checkOutput("fin_stop_count", int'(count), 8'h07);
    checkOutput("fin_stop_busy", int'(busy), 0);
    checkOutput("fin_stop_done", int'(done), 0);
    tick_clk();
    checkOutput("fin_stop_done2", int'(done), 0);

    // Reset mid-FREE with a LOAD presented.
    applyStimulus(1, 1, 0, 0);
    tick_clk();
    applyStimulus(0, 0, 0, 0);
    repeat (3) tick_clk();
    reset = 1'b1;
    applyStimulus(1, 3, 8'h55, 0);
    tick_clk();
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0);
    checkOutput("midrst_count", int'(count), 0);
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_done", int'(done), 0);
    checkOutput("midrst_wrap", int'(wrap), 0);

    // Randomized commands, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      tick_clk();
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 5) == 0) begin
        int op;
        int arg;
        op = int'($urandom_range(0, 3));
        if (op == 0) arg = int'($urandom_range(0, 6));
        else if ($urandom_range(0, 1) == 1) arg = int'($urandom_range(250, 255));
        else arg = int'($urandom_range(0, 255));
        applyStimulus(1, op, arg, int'($urandom_range(0, 3)));
      end else begin
        applyStimulus(0, int'($urandom_range(0, 3)), 0, 0);
      end
    end
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0);
    repeat (2) tick_clk();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
